// File: rtl/bot_permuter_pkg.sv
// Shared constants for the bottom permuter: permutation indices, (f,s,t) table
// and the one-var / two-var group lists.
package bot_permuter_pkg;

  localparam logic [2:0] PERM_ABC  = 3'd5;
  localparam logic [2:0] PERM_ACB  = 3'd4;
  localparam logic [2:0] PERM_BAC  = 3'd3;
  localparam logic [2:0] PERM_BCA  = 3'd2;
  localparam logic [2:0] PERM_CAB  = 3'd1;
  localparam logic [2:0] PERM_CBA  = 3'd0;
  localparam logic [2:0] PERM_NONE = 3'd7;

  // Element k is a group number; [0] is the first list entry.
  localparam logic [2:0][2:0] ONE_VAR_GROUPS = {3'd4, 3'd2, 3'd1};
  localparam logic [2:0][2:0] TWO_VAR_GROUPS = {3'd3, 3'd5, 3'd6};

  typedef struct packed {
    logic [1:0] f;
    logic [1:0] s;
    logic [1:0] t;
  } perm_fst_t;

  function automatic perm_fst_t perm_lookup(input logic [2:0] idx);
    perm_fst_t p;
    case (idx)
      PERM_ABC: p = '{f: 2'd0, s: 2'd1, t: 2'd2};
      PERM_ACB: p = '{f: 2'd0, s: 2'd2, t: 2'd1};
      PERM_BAC: p = '{f: 2'd1, s: 2'd0, t: 2'd2};
      PERM_BCA: p = '{f: 2'd1, s: 2'd2, t: 2'd0};
      PERM_CAB: p = '{f: 2'd2, s: 2'd0, t: 2'd1};
      PERM_CBA: p = '{f: 2'd2, s: 2'd1, t: 2'd0};
      default:  p = '{f: 2'd0, s: 2'd1, t: 2'd2};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/bot_permuter_stream_if.sv
// Stream bus of the bottom permuter: burst input side and permuted-word output side.
// Optional stats signals appear when BOT_PERMUTER_STATS_EN is defined.
interface bot_permuter_stream_if #(
  parameter int unsigned VAR_COUNT        = 7,
  parameter int unsigned EXTRA_DATA_WIDTH = 12
);
  localparam int unsigned BOT_W = 32'd1 << VAR_COUNT;

  logic                        inValid;
  logic                        inReady;
  logic [BOT_W-1:0]            botIn;
  logic [5:0]                  validPermutesIn;
  logic [EXTRA_DATA_WIDTH-1:0] extraDataIn;
  logic                        outValid;
  logic                        outReady;
  logic [BOT_W-1:0]            permutedBot;
  logic [2:0]                  selectedPermutationOut;
  logic                        lastOfBurst;
  logic [EXTRA_DATA_WIDTH-1:0] extraDataOut;
`ifdef BOT_PERMUTER_STATS_EN
  logic [31:0]                 emittedCount;
  logic [31:0]                 burstCount;
`endif

  modport master (
    output inValid, botIn, validPermutesIn, extraDataIn, outReady,
    input  inReady, outValid, permutedBot, selectedPermutationOut, lastOfBurst, extraDataOut
`ifdef BOT_PERMUTER_STATS_EN
    , emittedCount, burstCount
`endif
  );

  modport slave (
    input  inValid, botIn, validPermutesIn, extraDataIn, outReady,
    output inReady, outValid, permutedBot, selectedPermutationOut, lastOfBurst, extraDataOut
`ifdef BOT_PERMUTER_STATS_EN
    , emittedCount, burstCount
`endif
  );

endinterface

// File: rtl/bot_permute_select.sv
// Combinational group shuffle: applies permutation index sel to the top three
// variables of bot. Groups 0 and 7 pass through.
module bot_permute_select
  import bot_permuter_pkg::*;
#(
  parameter int unsigned VAR_COUNT = 7
) (
  input  logic [(32'd1 << VAR_COUNT)-1:0] bot,
  input  logic [2:0]                      sel,
  output logic [(32'd1 << VAR_COUNT)-1:0] permuted
);
  localparam int unsigned BOT_W = 32'd1 << VAR_COUNT;
  localparam int unsigned G     = BOT_W / 8;

  logic [G-1:0] grp_in  [8];
  logic [G-1:0] grp_out [8];
  perm_fst_t    p;

  always_comb begin
    p = perm_lookup(sel);
    for (int g = 0; g < 8; g++) grp_in[g] = bot[g*G +: G];
    grp_out = grp_in;
    grp_out[ONE_VAR_GROUPS[0]] = grp_in[ONE_VAR_GROUPS[p.f]];
    grp_out[ONE_VAR_GROUPS[1]] = grp_in[ONE_VAR_GROUPS[p.s]];
    grp_out[ONE_VAR_GROUPS[2]] = grp_in[ONE_VAR_GROUPS[p.t]];
    grp_out[TWO_VAR_GROUPS[0]] = grp_in[TWO_VAR_GROUPS[p.f]];
    grp_out[TWO_VAR_GROUPS[1]] = grp_in[TWO_VAR_GROUPS[p.s]];
    grp_out[TWO_VAR_GROUPS[2]] = grp_in[TWO_VAR_GROUPS[p.t]];
    permuted = '0;
    for (int g = 0; g < 8; g++) permuted[g*G +: G] = grp_out[g];
  end

endmodule

// File: rtl/bot_permuter_stream.sv
// Streaming bottom permuter: active + pending burst slots feeding a registered
// output word per cycle. Define BOT_PERMUTER_STATS_EN for emitted/burst counters.
module bot_permuter_stream
  import bot_permuter_pkg::*;
#(
  parameter int unsigned VAR_COUNT        = 7,
  parameter int unsigned EXTRA_DATA_WIDTH = 12,
  parameter int unsigned RST_PIPE_CYCLES  = 2
) (
  input logic                   clk,
  input logic                   rst,
  bot_permuter_stream_if.slave  bus
);
  localparam int unsigned BOT_W = 32'd1 << VAR_COUNT;
  localparam int unsigned XW    = EXTRA_DATA_WIDTH;

  // Reset retiming chain; run drops once rst has traversed every stage.
  logic [RST_PIPE_CYCLES-1:0] rst_pipe;
  logic run, ready_ok;

  always_ff @(posedge clk) begin
    rst_pipe[0] <= rst;
    for (int i = 1; i < int'(RST_PIPE_CYCLES); i++) rst_pipe[i] <= rst_pipe[i-1];
  end

  assign run      = rst_pipe[RST_PIPE_CYCLES-1];
  assign ready_ok = rst && (&rst_pipe);

  logic [5:0]       act_mask,  act_mask_nxt;
  logic [BOT_W-1:0] act_bot,   act_bot_nxt;
  logic [XW-1:0]    act_extra, act_extra_nxt;
  logic             pend_valid, pend_valid_nxt;
  logic [5:0]       pend_mask,  pend_mask_nxt;
  logic [BOT_W-1:0] pend_bot,   pend_bot_nxt;
  logic [XW-1:0]    pend_extra, pend_extra_nxt;
  logic             out_valid,  out_valid_nxt;
  logic [2:0]       out_sel,    out_sel_nxt;
  logic             out_last,   out_last_nxt;
  logic [BOT_W-1:0] out_bot,    out_bot_nxt;
  logic [XW-1:0]    out_extra,  out_extra_nxt;
  logic             in_ready,   in_ready_nxt;

  logic [2:0]       emit_idx;
  logic [5:0]       rem_mask;
  logic             adv, emit, act_free, accept;
  logic [BOT_W-1:0] perm_bot;

  bot_permute_select #(.VAR_COUNT(VAR_COUNT)) u_select (
    .bot      (act_bot),
    .sel      (emit_idx),
    .permuted (perm_bot)
  );

  always_comb begin
    emit_idx = PERM_NONE;
    for (int i = 0; i < 6; i++) if (act_mask[i]) emit_idx = 3'(i);
    rem_mask = act_mask & ~(6'd1 << emit_idx);
    adv      = !out_valid || bus.outReady;
    emit     = adv && (act_mask != 6'd0);
    act_free = (act_mask == 6'd0) || (emit && (rem_mask == 6'd0));
    // Empty-mask bursts handshake but never occupy a slot.
    accept   = bus.inValid && in_ready && (bus.validPermutesIn != 6'd0);

    act_mask_nxt   = emit ? rem_mask : act_mask;
    act_bot_nxt    = act_bot;
    act_extra_nxt  = act_extra;
    pend_valid_nxt = pend_valid;
    pend_mask_nxt  = pend_mask;
    pend_bot_nxt   = pend_bot;
    pend_extra_nxt = pend_extra;

    if (act_free && pend_valid) begin
      act_mask_nxt   = pend_mask;
      act_bot_nxt    = pend_bot;
      act_extra_nxt  = pend_extra;
      pend_valid_nxt = 1'b0;
    end else if (act_free && accept) begin
      act_mask_nxt  = bus.validPermutesIn;
      act_bot_nxt   = bus.botIn;
      act_extra_nxt = bus.extraDataIn;
    end else if (accept) begin
      pend_valid_nxt = 1'b1;
      pend_mask_nxt  = bus.validPermutesIn;
      pend_bot_nxt   = bus.botIn;
      pend_extra_nxt = bus.extraDataIn;
    end

    out_valid_nxt = out_valid;
    out_sel_nxt   = out_sel;
    out_last_nxt  = out_last;
    out_bot_nxt   = out_bot;
    out_extra_nxt = out_extra;
    if (adv) begin
      out_valid_nxt = emit;
      out_sel_nxt   = emit ? emit_idx : PERM_NONE;
      out_last_nxt  = emit && (rem_mask == 6'd0);
      if (emit) begin
        out_bot_nxt   = perm_bot;
        out_extra_nxt = act_extra;
      end
    end

    in_ready_nxt = ready_ok && !pend_valid_nxt;
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      act_mask   <= 6'd0;
      pend_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_sel    <= PERM_NONE;
      out_last   <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      act_mask   <= act_mask_nxt;
      pend_valid <= pend_valid_nxt;
      out_valid  <= out_valid_nxt;
      out_sel    <= out_sel_nxt;
      out_last   <= out_last_nxt;
      in_ready   <= in_ready_nxt;
    end
  end

  // Payload registers are qualified by the masks/valids above, so no reset.
  always_ff @(posedge clk) begin
    act_bot    <= act_bot_nxt;
    act_extra  <= act_extra_nxt;
    pend_mask  <= pend_mask_nxt;
    pend_bot   <= pend_bot_nxt;
    pend_extra <= pend_extra_nxt;
    out_bot    <= out_bot_nxt;
    out_extra  <= out_extra_nxt;
  end

  assign bus.inReady                = in_ready;
  assign bus.outValid               = out_valid;
  assign bus.permutedBot            = out_bot;
  assign bus.selectedPermutationOut = out_sel;
  assign bus.lastOfBurst            = out_last;
  assign bus.extraDataOut           = out_extra;

`ifdef BOT_PERMUTER_STATS_EN
  logic [31:0] emitted_cnt, burst_cnt;

  always_ff @(posedge clk) begin
    if (!run) begin
      emitted_cnt <= 32'd0;
      burst_cnt   <= 32'd0;
    end else if (out_valid && bus.outReady) begin
      emitted_cnt <= emitted_cnt + 32'd1;
      if (out_last) burst_cnt <= burst_cnt + 32'd1;
    end
  end

  assign bus.emittedCount = emitted_cnt;
  assign bus.burstCount   = burst_cnt;
`else
  // statistics counters not built
`endif

endmodule

// File: tb/tb_bot_permuter_stream.sv
// Bench for bot_permuter_stream: table-driven directed bursts, corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_bot_permuter_stream;
  localparam int BW = 128;
  localparam int G  = 16;
  localparam int XW = 12;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  bit   mon_en;

  bot_permuter_stream_if #(.VAR_COUNT(7), .EXTRA_DATA_WIDTH(XW)) bus ();

  bot_permuter_stream #(.VAR_COUNT(7), .EXTRA_DATA_WIDTH(XW), .RST_PIPE_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic        last;
    logic [31:0] nib;
  } vec_t;

  typedef struct {
    logic [BW-1:0] bot;
    logic [2:0]    sel;
    logic          last;
    logic [XW-1:0] extra;
  } exp_t;

  exp_t q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] mk_rec(input logic v, input logic [2:0] sel, input logic last,
                                          input logic [XW-1:0] x, input logic [BW-1:0] b);
    return {15'd0, v, sel, last, x, b};
  endfunction

  function automatic logic [159:0] out_rec();
    return mk_rec(bus.outValid, bus.selectedPermutationOut, bus.lastOfBurst, bus.extraDataOut,
                  bus.permutedBot);
  endfunction

  // Each group g holds four copies of nibble g of nib.
  function automatic logic [BW-1:0] expand(input logic [31:0] nib);
    logic [BW-1:0] r;
    for (int g = 0; g < 8; g++) r[g*G +: G] = {4{nib[g*4 +: 4]}};
    return r;
  endfunction

  // Reference: rebuild the word group by group from the (f,s,t) rule.
  function automatic logic [BW-1:0] model_perm(input logic [BW-1:0] b, input int idx);
    int ord[3];
    int one_l[3];
    int two_l[3];
    logic [G-1:0] grp[8];
    logic [BW-1:0] r;
    one_l = '{1, 2, 4};
    two_l = '{6, 5, 3};
    case (idx)
      5: ord = '{0, 1, 2};
      4: ord = '{0, 2, 1};
      3: ord = '{1, 0, 2};
      2: ord = '{1, 2, 0};
      1: ord = '{2, 0, 1};
      default: ord = '{2, 1, 0};
    endcase
    for (int g = 0; g < 8; g++) grp[g] = b[g*G +: G];
    r = b;
    for (int k = 0; k < 3; k++) begin
      r[one_l[k]*G +: G] = grp[one_l[ord[k]]];
      r[two_l[k]*G +: G] = grp[two_l[ord[k]]];
    end
    return r;
  endfunction

  task automatic push_burst(input logic [BW-1:0] b, input logic [5:0] mask, input logic [XW-1:0] x);
    exp_t e;
    logic [5:0] lower;
    for (int i = 5; i >= 0; i--) begin
      if (mask[i]) begin
        lower   = 6'((32'd1 << i) - 32'd1);
        e.bot   = model_perm(b, i);
        e.sel   = 3'(i);
        e.last  = ((mask & lower) == 6'd0);
        e.extra = x;
        q.push_back(e);
      end
    end
  endtask

  // Scoreboard and stall-stability monitor for the randomized phase.
  logic [159:0] snap;
  bit           hold_pending;
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (hold_pending) check("hold_stable", out_rec(), snap);
      hold_pending = bus.outValid && !bus.outReady;
      snap = out_rec();
      if (bus.outValid && bus.outReady) begin
        if (q.size() == 0) begin
          check("unexpected_output", {159'd0, 1'b1}, 160'd0);
        end else begin
          e = q.pop_front();
          check("stream_word", out_rec(), mk_rec(1'b1, e.sel, e.last, e.extra, e.bot));
        end
      end
      if (bus.inValid && bus.inReady) push_burst(bus.botIn, bus.validPermutesIn, bus.extraDataIn);
    end
  end

  vec_t          tbl[6];
  logic [BW-1:0] ident;
  logic [159:0]  held;
  int            seen;
  bit            acc;

  initial begin
    checks = 0;
    failures = 0;
    mon_en = 1'b0;
    hold_pending = 1'b0;
    tbl[0] = '{3'd5, 1'b0, 32'h76543210};
    tbl[1] = '{3'd4, 1'b0, 32'h76325410};
    tbl[2] = '{3'd3, 1'b0, 32'h75643120};
    tbl[3] = '{3'd2, 1'b0, 32'h75316420};
    tbl[4] = '{3'd1, 1'b0, 32'h73625140};
    tbl[5] = '{3'd0, 1'b1, 32'h73516240};
    ident = expand(32'h76543210);

    rst = 1'b0;
    bus.inValid = 1'b0;
    bus.botIn = '0;
    bus.validPermutesIn = 6'd0;
    bus.extraDataIn = '0;
    bus.outReady = 1'b1;
    repeat (6) tick();
    check("rst_outValid", 160'(bus.outValid), 160'd0);
    check("rst_sel", 160'(bus.selectedPermutationOut), 160'd7);
    check("rst_last", 160'(bus.lastOfBurst), 160'd0);
    check("rst_inReady", 160'(bus.inReady), 160'd0);
    rst = 1'b1;
    for (int i = 0; i < 10 && !bus.inReady; i++) tick();
    check("release_inReady", 160'(bus.inReady), 160'd1);

    // Full-mask burst, table of expected words.
    bus.inValid = 1'b1;
    bus.botIn = ident;
    bus.validPermutesIn = 6'b111111;
    bus.extraDataIn = 12'hABC;
    tick();
    check("s1_latency", 160'(bus.outValid), 160'd0);
    bus.inValid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("s1_word%0d", k), out_rec(),
            mk_rec(1'b1, tbl[k].sel, tbl[k].last, 12'hABC, expand(tbl[k].nib)));
    end
    tick();
    check("s1_idle", 160'(bus.outValid), 160'd0);

    // Back-to-back bursts through the pending slot.
    bus.inValid = 1'b1;
    bus.validPermutesIn = 6'b000101;
    bus.extraDataIn = 12'h111;
    tick();
    check("s2_ready_a", 160'(bus.inReady), 160'd1);
    bus.validPermutesIn = 6'b100000;
    bus.extraDataIn = 12'h222;
    tick();
    bus.inValid = 1'b0;
    check("s2_out0", out_rec(), mk_rec(1'b1, 3'd2, 1'b0, 12'h111, expand(tbl[3].nib)));
    check("s2_pend_full", 160'(bus.inReady), 160'd0);
    tick();
    check("s2_out1", out_rec(), mk_rec(1'b1, 3'd0, 1'b1, 12'h111, expand(tbl[5].nib)));
    tick();
    check("s2_out2", out_rec(), mk_rec(1'b1, 3'd5, 1'b1, 12'h222, ident));
    tick();
    check("s2_idle", 160'(bus.outValid), 160'd0);
`ifdef BOT_PERMUTER_STATS_EN
    check("stats_emitted", 160'(bus.emittedCount), 160'd9);
    check("stats_bursts", 160'(bus.burstCount), 160'd3);
`endif

    // Consumer stall mid-burst.
    bus.inValid = 1'b1;
    bus.validPermutesIn = 6'b111111;
    bus.extraDataIn = 12'h333;
    tick();
    bus.inValid = 1'b0;
    tick();
    tick();
    bus.outReady = 1'b0;
    held = mk_rec(1'b1, 3'd4, 1'b0, 12'h333, expand(tbl[1].nib));
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("s3_hold%0d", k), out_rec(), held);
    end
    bus.outReady = 1'b1;
    for (int k = 2; k < 6; k++) begin
      tick();
      check($sformatf("s3_word%0d", k), out_rec(),
            mk_rec(1'b1, tbl[k].sel, tbl[k].last, 12'h333, expand(tbl[k].nib)));
    end
    tick();
    check("s3_idle", 160'(bus.outValid), 160'd0);

    // Empty mask is swallowed, following burst emits alone.
    bus.inValid = 1'b1;
    bus.validPermutesIn = 6'b000000;
    bus.extraDataIn = 12'h444;
    tick();
    bus.validPermutesIn = 6'b010000;
    bus.extraDataIn = 12'h555;
    tick();
    bus.inValid = 1'b0;
    check("s4_no_output", 160'(bus.outValid), 160'd0);
    tick();
    check("s4_word", out_rec(), mk_rec(1'b1, 3'd4, 1'b1, 12'h555, expand(tbl[1].nib)));
    tick();
    check("s4_idle", 160'(bus.outValid), 160'd0);

    // Reset pulse during a burst.
    bus.inValid = 1'b1;
    bus.validPermutesIn = 6'b111111;
    tick();
    bus.inValid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (4) tick();
    check("s5_outValid", 160'(bus.outValid), 160'd0);
    check("s5_sel", 160'(bus.selectedPermutationOut), 160'd7);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.outValid) seen++;
    end
    check("s5_no_more_outputs", 160'(seen), 160'd0);
    check("s5_inReady", 160'(bus.inReady), 160'd1);

    // Randomized traffic against the model.
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      acc = bus.inValid && bus.inReady;
      tick();
      if (acc || !bus.inValid) begin
        if ($urandom_range(0, 1) == 1) begin
          bus.inValid = 1'b1;
          bus.botIn = {$urandom, $urandom, $urandom, $urandom};
          bus.validPermutesIn = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
          bus.extraDataIn = 12'($urandom);
        end else begin
          bus.inValid = 1'b0;
        end
      end
      bus.outReady = ($urandom_range(0, 3) != 0);
    end
    acc = bus.inValid && bus.inReady;
    tick();
    if (!acc) begin
      for (int i = 0; i < 20 && !(bus.inValid && bus.inReady); i++) tick();
      tick();
    end
    bus.inValid = 1'b0;
    bus.outReady = 1'b1;
    for (int i = 0; i < 200 && (q.size() != 0 || bus.outValid); i++) tick();
    tick();
    check("drain_queue_empty", 160'(q.size()), 160'd0);
    check("drain_idle", 160'(bus.outValid), 160'd0);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bot_permuter_stream.md
Name: bot_permuter_stream

Overview:
- Parametrised successor of the 3-variable bottom permuter.
- Takes a monotone-function bot of VAR_COUNT variables plus a 6-bit mask of valid permutations of its top 3 variables, and emits one permuted bot per cycle.
- Adds valid/ready backpressure on both sides and a one-deep pending slot, so the next burst is accepted while the current one drains.
- Sits between the bot source queue and the permutation-check pipeline.

Parameters:
- VAR_COUNT, 7, number of function variables; bot width = 2^VAR_COUNT; legal range 3..9.
- EXTRA_DATA_WIDTH, 12, sideband carried unchanged with every output of a burst.
- RST_PIPE_CYCLES, 2, reset register stages, built with the existing hyperpipe.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- inValid  in  1  a burst is offered
- inReady  out  1  pending slot empty, burst accepted when inValid&&inReady
- botIn  in  2^VAR_COUNT  bot; group g (g=0..7) = bits [g*G +: G], where G=2^(VAR_COUNT-3)
- validPermutesIn  in  6  {ABC,ACB,BAC,BCA,CAB,CBA}, bit5..bit0
- extraDataIn  in  EXTRA_DATA_WIDTH  sideband
- outValid  out  1  output word valid
- outReady  in  1  consumer accepts when outValid&&outReady
- permutedBot  out  2^VAR_COUNT  permuted bot
- selectedPermutationOut  out  3  permutation index 5..0
- lastOfBurst  out  1  final output of its burst
- extraDataOut  out  EXTRA_DATA_WIDTH  sideband of the burst

Behaviour:
- Reset (rst low, sampled after RST_PIPE_CYCLES): active and pending slots empty, outValid=0, lastOfBurst=0, selectedPermutationOut=7, inReady=0 while reset is held. inReady=1 on the first cycle after reset is released. Data outputs are don't-care.
- Mid-operation reset drops all held bursts; no partial output follows release.
- Permutation map, as (f,s,t): 5=(0,1,2), 4=(0,2,1), 3=(1,0,2), 2=(1,2,0), 1=(2,0,1), 0=(2,1,0).
- Group lists: one-var list = groups {1,2,4}; two-var list = groups {6,5,3}.
- Output groups 0 and 7 are copied unchanged.
- Output group1 = one[f], group2 = one[s], group4 = one[t].
- Output group6 = two[f], group5 = two[s], group3 = two[t].
- Emission order within a burst: highest set mask bit first. Each accepted output clears that bit.
- lastOfBurst=1 when the emitted bit is the only remaining bit.
- A burst with mask 000000 is accepted and discarded; no output, no stall.
- Slots: an accepted burst goes to the active slot if active is empty or finishing this cycle, else to the pending slot. When the active slot empties, pending moves to active on the same edge.
- Output register advances when !outValid || outReady; otherwise it holds all outputs stable.
- Latency: burst accepted at edge t into an idle block gives outValid high after edge t+1.
- Throughput: one output per cycle with outReady=1, including back-to-back bursts with no bubble.
- Simultaneous events:
  - Accept into pending and active draining in the same cycle is legal.
  - Accept while pending is full is impossible, since inReady=0.

Optional Feature:
- Macro: BOT_PERMUTER_STATS_EN.
- When defined, adds output emittedCount (32 bits) and burstCount (32 bits).
  - emittedCount increments on each output handshake.
  - burstCount increments on each handshake with lastOfBurst=1.
  - Both wrap modulo 2^32 and reset to 0.
- When undefined, the ports and logic are absent.

Decomposition:
- Package bot_permuter_pkg: permutation index constants (PERM_ABC=5 .. PERM_CBA=0, PERM_NONE=7), the (f,s,t) lookup table, and group-index constants for the one-var and two-var lists.
- Sub-module: bot_permute_select, combinational. Inputs are bot and a 3-bit index; output is the permuted bot, parametrised by VAR_COUNT.

Test Plan:
- VAR_COUNT=7, group g=16'hgggg, mask 111111, outReady=1: six outputs with sel 5,4,3,2,1,0 and lastOfBurst only on the 6th. The sel=3 word has groups 0..7 = 0000,2222,1111,3333,4444,6666,5555,7777.
- Two bursts back-to-back, masks 000101 and 100000: outputs sel 2,0,5 on consecutive cycles; lastOfBurst on the 2nd and 3rd outputs; inReady drops while pending is full.
- outReady low for 4 cycles mid-burst: outputs held bit-identical; no permutation skipped or repeated.
- Mask 000000 followed by mask 010000: only one output (sel 4, lastOfBurst=1), with extraDataOut of the second burst.
- rst low for 1 cycle during a 6-output burst: outValid=0 after the reset pipe; no further outputs until a new accept; selectedPermutationOut=7.
- STATS_EN defined, then the first two scenarios run: emittedCount=9, burstCount=3.
